// File: rtl/icache_pkg.sv
// Shared icache geometry and loader state encoding.
package icache_pkg;

    localparam int ICACHE_ADDR_W = 12;
    localparam int ICACHE_DATA_W = 32;
    localparam int ICACHE_DEPTH  = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word assembler; word_vld is combinational on the last byte.
// Never stalls: every qualified byte is absorbed in the cycle it arrives.
module byte_word_packer #(
    parameter int BYTE_W = 8,
    parameter int DATA_W = 32,
    localparam int LANES = DATA_W / BYTE_W,
    localparam int IDX_W = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_vld,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic [IDX_W-1:0]  i_last_idx,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_vld
);

    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_word;

    // Current byte merged into its lane so the completed word is usable on the same edge.
    always_comb begin
        w_word = r_word;
        for (int i = 0; i < LANES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_word[i*BYTE_W +: BYTE_W] = i_byte;
            end
        end
    end

    assign o_word     = w_word;
    assign o_word_vld = i_vld && (r_idx == i_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_vld) begin
            r_word <= w_word;
            r_idx  <= (r_idx == i_last_idx) ? '0 : r_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/icache_loader.sv
// Loads the icache from a byte stream: 2-byte LE length header, then LE words.
// One registered write per word, one cycle after its 4th byte; accepts a byte every cycle in HDR/DATA.
module icache_loader
    import icache_pkg::*;
#(
    parameter int ADDR_W = ICACHE_ADDR_W,
    parameter int DATA_W = ICACHE_DATA_W,
    parameter int BYTE_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

    localparam int LANES = DATA_W / BYTE_W;
    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] HDR_LAST  = IDX_W'(LEN_W / BYTE_W - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(LANES - 1);
    localparam logic [LEN_W:0]   MAX_LEN   = (LEN_W + 1)'(1) << ADDR_W;

    loader_state_t     r_state;
    loader_state_t     w_nxt_state;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [LEN_W-1:0]  r_len;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W:0]   r_words;

    logic              w_busy;
    logic              w_accept;
    logic              w_pk_vld;
    logic              w_pk_clr;
    logic [IDX_W-1:0]  w_last_idx;
    logic [DATA_W-1:0] w_pk_word;
    logic              w_pk_word_vld;
    logic [LEN_W-1:0]  w_hdr_len;
    logic              w_len_bad;
    logic [ADDR_W:0]   w_words_nxt;
    logic              w_last_word;

    assign w_busy      = (r_state == HDR) || (r_state == DATA);
    assign w_accept    = in_valid && w_busy;
    // A byte arriving with abort is dropped before it reaches the packer.
    assign w_pk_vld    = w_accept && !abort;
    assign w_pk_clr    = ((r_state == IDLE) && start) || (w_busy && abort);
    assign w_last_idx  = (r_state == HDR) ? HDR_LAST : DATA_LAST;
    assign w_hdr_len   = w_pk_word[LEN_W-1:0];
    assign w_len_bad   = (w_hdr_len == '0) || ({1'b0, w_hdr_len} > MAX_LEN);
    assign w_words_nxt = r_words + (ADDR_W + 1)'(1);
    assign w_last_word = (LEN_W'(w_words_nxt) == r_len);

    byte_word_packer #(
        .BYTE_W (BYTE_W),
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_pk_clr),
        .i_vld      (w_pk_vld),
        .i_byte     (in_data),
        .i_last_idx (w_last_idx),
        .o_word     (w_pk_word),
        .o_word_vld (w_pk_word_vld)
    );

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            IDLE: if (start) w_nxt_state = HDR;
            HDR: begin
                if (abort)              w_nxt_state = IDLE;
                else if (w_pk_word_vld) w_nxt_state = w_len_bad ? IDLE : DATA;
            end
            DATA: begin
                if (abort)                             w_nxt_state = IDLE;
                else if (w_pk_word_vld && w_last_word) w_nxt_state = DONE;
            end
            DONE:    w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr_cnt <= '0;
            r_len      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_words    <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr_cnt <= base_addr;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_words    <= '0;
                    end
                end
                HDR: begin
                    if (abort) begin
                        r_error <= 1'b1;
                    end else if (w_pk_word_vld) begin
                        r_len <= w_hdr_len;
                        if (w_len_bad) r_error <= 1'b1;
                    end
                end
                DATA: begin
                    if (abort) begin
                        r_error <= 1'b1;
                    end else if (w_pk_word_vld) begin
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= r_addr_cnt;
                        r_wr_data  <= w_pk_word;
                        r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
                        r_words    <= w_words_nxt;
                        // done is raised on entry so it is already high during DONE.
                        if (w_last_word) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = w_busy;
    assign busy          = w_busy;
    assign wr_en         = r_wr_en;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words;

endmodule

// File: tb/tb_icache_loader.sv
// Directed bench for icache_loader: expected writes and flags are hand-computed per step.
module tb_icache_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [11:0] base_addr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_written;

    int checks;
    int failures;

    logic [11:0] log_a[$];
    logic [31:0] log_d[$];
    int          cnt[4096];
    logic [31:0] mem[4096];

    icache_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write capture on the falling edge, mid-way through the cycle wr_en is held.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_a.push_back(wr_addr);
            log_d.push_back(wr_data);
            cnt[wr_addr] = cnt[wr_addr] + 1;
            mem[wr_addr] = wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input int idx, input logic [11:0] ea, input logic [31:0] ed);
        if (idx < log_a.size()) begin
            chk({tag, "_addr"}, 32'(log_a[idx]), 32'(ea));
            chk({tag, "_data"}, log_d[idx], ed);
        end else begin
            chk({tag, "_missing"}, 32'(log_a.size()), 32'(idx + 1));
        end
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[i*8 +: 8], 0);
    endtask

    // 02 00 | 13 00 00 00 | 93 00 10 00, optionally with idle gaps between bytes.
    task automatic send_basic(input bit gaps);
        logic [7:0] b[10];
        int         g[10];
        b = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        g = '{0, 2, 0, 1, 3, 0, 0, 1, 0, 2};
        for (int i = 0; i < 10; i++) send(b[i], gaps ? g[i] : 0);
    endtask

    task automatic check_basic(input string tag);
        chk({tag, "_nwr"}, 32'(log_a.size()), 32'd2);
        chk_write({tag, "_w0"}, 0, 12'h010, 32'h0000_0013);
        chk_write({tag, "_w1"}, 1, 12'h011, 32'h0010_0093);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(words_written), 32'd2);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int bad;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        for (int i = 0; i < 4096; i++) begin
            cnt[i] = 0;
            mem[i] = '0;
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);

        // Basic load, back-to-back bytes
        clear_log();
        do_start(12'h010);
        chk("basic_busy_hdr", 32'(busy), 32'd1);
        chk("basic_ready_hdr", 32'(in_ready), 32'd1);
        send_basic(1'b0);
        chk("basic_wr_en_last", 32'(wr_en), 32'd1);
        chk("basic_done_in_done", 32'(done), 32'd1);
        tick();
        tick();
        check_basic("basic");

        // Bytes offered in IDLE are dropped; gapped stream yields identical writes
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        chk("idle_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        in_valid = 1'b0;
        chk("idle_no_hdr", 32'(busy), 32'd0);
        do_start(12'h010);
        chk("gap_done_cleared", 32'(done), 32'd0);
        send_basic(1'b1);
        tick();
        tick();
        check_basic("gap");

        // Wrap-around from 0xFFF
        clear_log();
        do_start(12'hFFF);
        send(8'h02, 0);
        send(8'h00, 0);
        send_word(32'hDEAD_BEEF);
        send_word(32'h1234_5678);
        tick();
        tick();
        chk("wrap_nwr", 32'(log_a.size()), 32'd2);
        chk_write("wrap_w0", 0, 12'hFFF, 32'hDEAD_BEEF);
        chk_write("wrap_w1", 1, 12'h000, 32'h1234_5678);
        chk("wrap_err", 32'(error), 32'd0);
        chk("wrap_done", 32'(done), 32'd1);

        // len = 0
        clear_log();
        do_start(12'h020);
        send(8'h00, 0);
        send(8'h00, 0);
        chk("len0_err", 32'(error), 32'd1);
        chk("len0_ready", 32'(in_ready), 32'd0);
        chk("len0_done", 32'(done), 32'd0);
        send(8'h55, 0);
        send(8'h66, 0);
        tick();
        chk("len0_nwr", 32'(log_a.size()), 32'd0);

        // len = 0x1001
        do_start(12'h020);
        chk("len1001_err_cleared", 32'(error), 32'd0);
        send(8'h01, 0);
        send(8'h10, 0);
        chk("len1001_err", 32'(error), 32'd1);
        chk("len1001_busy", 32'(busy), 32'd0);
        tick();
        chk("len1001_nwr", 32'(log_a.size()), 32'd0);

        // Abort on the 3rd byte of word 1 of a 3-word load
        clear_log();
        do_start(12'h100);
        send(8'h03, 0);
        send(8'h00, 0);
        send_word(32'h4433_2211);
        send(8'h55, 0);
        send(8'h66, 0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_err", 32'(error), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_words", 32'(words_written), 32'd1);
        tick();
        chk("abort_nwr", 32'(log_a.size()), 32'd1);
        chk_write("abort_w0", 0, 12'h100, 32'h4433_2211);
        clear_log();
        do_start(12'h010);
        send_basic(1'b0);
        tick();
        tick();
        check_basic("post_abort");

        // Asynchronous reset mid-DATA, between clock edges
        clear_log();
        do_start(12'h200);
        send(8'h02, 0);
        send(8'h00, 0);
        send_word(32'hCAFE_F00D);
        chk("arst_wr_en_pre", 32'(wr_en), 32'd1);
        send(8'h01, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_words", 32'(words_written), 32'd0);
        chk("arst_wr_addr", 32'(wr_addr), 32'd0);
        chk("arst_wr_data", wr_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        do_start(12'h010);
        send_basic(1'b0);
        tick();
        tick();
        check_basic("post_arst");

        // Maximum length: 4096 words starting mid-array
        clear_log();
        for (int i = 0; i < 4096; i++) begin
            cnt[i] = 0;
            mem[i] = '0;
        end
        do_start(12'h800);
        send(8'h00, 0);
        send(8'h10, 0);
        chk("full_no_err_hdr", 32'(error), 32'd0);
        for (int k = 0; k < 4096; k++) send_word(32'hC0DE_0000 | 32'(k));
        tick();
        tick();
        bad = 0;
        for (int a = 0; a < 4096; a++) begin
            if (cnt[a] != 1 || mem[a] !== (32'hC0DE_0000 | 32'((a - 12'h800) & 12'hFFF))) bad++;
        end
        chk("full_cover", 32'(bad), 32'd0);
        chk("full_nwr", 32'(log_a.size()), 32'd4096);
        chk("full_done", 32'(done), 32'd1);
        chk("full_err", 32'(error), 32'd0);
        chk("full_words", 32'(words_written), 32'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
